alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
- Initiator side of the ALU data/control channel. Accepts operand-pair commands on a valid/ready stream and drives operands inp1/inp2 plus op onto a fixed-latency ALU.
- Captures the ALU's out1 exactly ALU_LAT cycles after each issue and returns results in order on a valid/ready output stream.
- Credit-based issue guarantees results are never lost under output backpressure.

Parameters:
- DATA_W, 64, width of inp1/inp2/out1.
- ALU_LAT, 3, cycles from alu_issue to alu_out1 valid (>=1).
- FIFO_DEPTH, 8, result FIFO entries (power of 2, >= ALU_LAT+1).

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- s_valid  in  1  command valid.
- s_ready  out  1  command ready.
- s_op  in  2  opcode, op_list encoding (ADD=0, SUB=1; 2,3 illegal).
- s_inp1  in  DATA_W  operand 1.
- s_inp2  in  DATA_W  operand 2.
- s_last  in  1  final command of packet.
- alu_issue  out  1  operands valid this cycle.
- alu_op  out  2  opcode to ALU.
- alu_inp1  out  DATA_W  operand 1 to ALU.
- alu_inp2  out  DATA_W  operand 2 to ALU.
- alu_out1  in  DATA_W  ALU result, valid ALU_LAT cycles after alu_issue.
- m_valid  out  1  result valid.
- m_ready  in  1  result ready.
- m_data  out  DATA_W  result.
- m_last  out  1  last result of packet.
- busy  out  1  state != IDLE.
- err_op  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset (async, active-low): state=IDLE; s_ready=0 during reset, then 1 from the first cycle after deassertion. alu_issue, alu_op, alu_inp1, alu_inp2, m_valid, m_data, m_last, busy, err_op all 0. FIFO empty, credits=FIFO_DEPTH, tracking pipeline cleared.
- Reset mid-operation: in-flight and buffered results are discarded with no output.
- Handshake: a transfer occurs when valid&&ready on the same edge.
- s_ready is combinational from state and credits, never from s_valid.
- m_valid/m_data/m_last stay stable while m_valid&&!m_ready.
- Issue: on a command handshake, alu_issue=1 in the next cycle with registered alu_op/alu_inp1/alu_inp2. With no handshake, alu_issue=0 and the data outputs hold their values.
- Issue is 1 cycle after accept; back-to-back issue is allowed at one command per cycle.
- Tracking pipeline: ALU_LAT-deep shift register of {vld, last, bad}, loaded at issue.
- When a stage exits, alu_out1 is pushed to the FIFO, replaced by 0 if bad=1.
- Credits: credits = FIFO_DEPTH − (FIFO occupancy + in-flight).
- Decrement on accept; increment on m handshake. Simultaneous accept and pop leaves credits unchanged.
- s_ready=0 when credits==0, so the FIFO can never overflow.
- FIFO push-while-full is impossible by construction. Pop-while-empty cannot occur because m_valid = !empty.
- Illegal op (2 or 3): the command is still accepted and issued with alu_op forced to ADD (0) and bad=1. The result is output as 0 and last is preserved. err_op is set on accept and cleared only by reset.
- Latency: an idle-path result appears on m_valid ALU_LAT+2 cycles after the command handshake edge. That is 1 issue register, ALU_LAT cycles, then the FIFO write; FIFO read is first-word-fall-through.
- FSM:
  - IDLE→RUN on the first accept.
  - RUN→DRAIN on an accept with s_last=1.
  - DRAIN: s_ready=0; → IDLE on the m handshake with m_last=1.
  - A first command with s_last=1 goes IDLE→DRAIN directly.
  - In IDLE/RUN, s_ready = (credits>0).
- Arithmetic: none in the issuer. Widths pass through unchanged; the pointer and credit counters are $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package: extend op_list to a 2-bit logic-based enum with explicit ADD=2'd0, SUB=2'd1. Add OP_W=2 and an issuer state enum {IDLE, RUN, DRAIN}.
- One sub-module: res_fifo, a synchronous first-word-fall-through FIFO. Parameters DATA_W+1 width (data+last) and FIFO_DEPTH; same ap_clk/ap_rst_n.

Test Plan:
- Single command ADD, inp1=5, inp2=7, last=1, with a model ALU computing inp1+inp2 with ALU_LAT=3 and m_ready=1 → m_data=12, m_last=1, m_valid rises 5 cycles after the accept edge. busy goes 1→0 after the output handshake.
- Burst of 8 SUB commands (inp1=100+i, inp2=i, last on i=7) with m_ready=0 → exactly 8 accepted, then s_ready=0. Raising m_ready yields eight results of 100 in order, with m_last only on the 8th.
- Continuous stream of 20 commands, m_ready toggling 1010… → no drop or duplication, order preserved, credits never negative, s_ready never high when credits==0.
- Command with s_op=3, inp1=9, inp2=4, last=1 → alu_op=0 at issue, m_data=0, err_op=1 and sticky across a following legal packet.
- ap_rst_n asserted low while 3 results are in flight and 2 are buffered → all outputs 0 immediately. After release: no stale m_valid, s_ready=1, credits=8.
- After DRAIN entry, s_valid held high with a new command → not accepted until the cycle after the m_last handshake, then accepted and issued normally.

Source files
------------

// File: rtl/alu_op_issuer_pkg.sv
// Shared types for the ALU operand issuer: opcode encoding, issuer FSM states
// and the per-issue tracking record that follows each command through the ALU.
package alu_op_issuer_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        ADD = 2'd0,
        SUB = 2'd1
    } op_list;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } issuer_state_t;

    typedef struct packed {
        logic vld;
        logic last;
        logic bad;
    } trk_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op == ADD) || (op == SUB);
    endfunction

endpackage

// File: rtl/alu_op_issuer_res_fifo.sv
// Synchronous first-word-fall-through result FIFO; the head entry is visible
// on pop_data whenever empty is low, and reads as zero while empty.
module res_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Zero while empty so the result bus is clean after reset and between packets.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge ap_clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Initiator side of the ALU channel: registers commands onto a fixed-latency
// ALU, tracks them to capture alu_out1, and returns results in order under credit control.
module alu_op_issuer
    import alu_op_issuer_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int ALU_LAT    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [OP_W-1:0]   s_op,
    input  logic [DATA_W-1:0] s_inp1,
    input  logic [DATA_W-1:0] s_inp2,
    input  logic              s_last,
    output logic              alu_issue,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_inp1,
    output logic [DATA_W-1:0] alu_inp2,
    input  logic [DATA_W-1:0] alu_out1,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              err_op
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    issuer_state_t     state;
    issuer_state_t     state_nxt;
    logic              ready_en;
    logic [CW-1:0]     credits;
    logic              accept;
    logic              pop;
    logic              issue_last;
    logic              issue_bad;
    trk_t              trk [ALU_LAT];
    logic [DATA_W-1:0] cap_data_in;
    logic              cap_vld;
    logic [DATA_W:0]   cap_word;
    logic [DATA_W:0]   fifo_head;
    logic              fifo_empty;

    // ready_en keeps s_ready low while reset is held and until the first clock after release.
    assign s_ready = ready_en && (state != DRAIN) && (credits != '0);
    assign accept  = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign busy    = (state != IDLE);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = s_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept && s_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            credits <= CW'(FIFO_DEPTH);
        end else begin
            unique case ({accept, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            alu_issue  <= 1'b0;
            alu_op     <= '0;
            alu_inp1   <= '0;
            alu_inp2   <= '0;
            issue_last <= 1'b0;
            issue_bad  <= 1'b0;
            err_op     <= 1'b0;
        end else begin
            alu_issue <= accept;
            if (accept) begin
                // Illegal opcodes still occupy an ALU slot so ordering and credits stay uniform.
                alu_op     <= op_legal(s_op) ? s_op : ADD;
                alu_inp1   <= s_inp1;
                alu_inp2   <= s_inp2;
                issue_last <= s_last;
                issue_bad  <= !op_legal(s_op);
                if (!op_legal(s_op)) begin
                    err_op <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int unsigned i = 0; i < ALU_LAT; i++) begin
                trk[i] <= '0;
            end
        end else begin
            trk[0] <= {alu_issue, issue_last, issue_bad};
            for (int unsigned i = 1; i < ALU_LAT; i++) begin
                trk[i] <= trk[i-1];
            end
        end
    end

    assign cap_data_in = trk[ALU_LAT-1].bad ? '0 : alu_out1;

    // alu_out1 is valid in the same cycle the tracker exits; register it before the FIFO write.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cap_vld  <= 1'b0;
            cap_word <= '0;
        end else begin
            cap_vld <= trk[ALU_LAT-1].vld;
            if (trk[ALU_LAT-1].vld) begin
                cap_word <= {trk[ALU_LAT-1].last, cap_data_in};
            end
        end
    end

    res_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .push      (cap_vld),
        .push_data (cap_word),
        .pop       (pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_last  = fifo_head[DATA_W];
    assign m_data  = fifo_head[DATA_W-1:0];

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a behavioural fixed-latency ALU and
// an output monitor that logs result handshakes and checks hold/credit rules.
module tb_alu_op_issuer;

    localparam int DATA_W     = 64;
    localparam int ALU_LAT    = 3;
    localparam int FIFO_DEPTH = 8;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              s_valid;
    logic              s_ready;
    logic [1:0]        s_op;
    logic [DATA_W-1:0] s_inp1;
    logic [DATA_W-1:0] s_inp2;
    logic              s_last;
    logic              alu_issue;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] alu_inp1;
    logic [DATA_W-1:0] alu_inp2;
    logic [DATA_W-1:0] alu_out1;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              err_op;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] rx_data [$];
    logic              rx_last [$];
    logic [DATA_W-1:0] exp3 [20];
    logic [DATA_W-1:0] alu_pipe [ALU_LAT];
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;
    int                sent;
    int                cyc;
    logic              acc;

    always #5 ap_clk = ~ap_clk;

    alu_op_issuer #(
        .DATA_W     (DATA_W),
        .ALU_LAT    (ALU_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_op      (s_op),
        .s_inp1    (s_inp1),
        .s_inp2    (s_inp2),
        .s_last    (s_last),
        .alu_issue (alu_issue),
        .alu_op    (alu_op),
        .alu_inp1  (alu_inp1),
        .alu_inp2  (alu_inp2),
        .alu_out1  (alu_out1),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .err_op    (err_op)
    );

    // ALU model: result of the issue cycle appears ALU_LAT cycles later.
    always @(posedge ap_clk) begin
        alu_pipe[0] <= alu_issue ? ((alu_op == 2'd1) ? alu_inp1 - alu_inp2 : alu_inp1 + alu_inp2) : '0;
        for (int i = 1; i < ALU_LAT; i++) begin
            alu_pipe[i] <= alu_pipe[i-1];
        end
    end
    assign alu_out1 = alu_pipe[ALU_LAT-1];

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input logic last);
        s_valid = 1'b1;
        s_op    = op;
        s_inp1  = a;
        s_inp2  = b;
        s_last  = last;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (rx_data.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk(tag, rx_data.size(), n);
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_last.delete();
    endtask

    // Inputs change just after posedge, so negedge values are what the next edge sees.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (m_valid && m_ready) begin
                rx_data.push_back(m_data);
                rx_last.push_back(m_last);
            end
            if (prev_stall) begin
                chk("m_hold_valid", m_valid, 1);
                chk("m_hold_data", m_data, prev_data);
                chk("m_hold_last", m_last, prev_last);
            end
            chk("credit_range", dut.credits <= FIFO_DEPTH, 1);
            if (dut.credits == 0) begin
                chk("ready_no_credit", s_ready, 0);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        s_valid = 1'b0;
        s_op    = '0;
        s_inp1  = '0;
        s_inp2  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_alu_issue", alu_issue, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_inp1", alu_inp1, 0);
        chk("rst_alu_inp2", alu_inp2, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_op", err_op, 0);
        #2 ap_rst_n = 1'b1;
        tick();
        chk("rel_s_ready", s_ready, 1);
        chk("rel_credits", dut.credits, 8);

        // Single ADD: 5+7, latency ALU_LAT+2 edges after accept
        m_ready = 1'b1;
        drive_cmd(2'd0, 5, 7, 1'b1);
        chk("t1_ready", s_ready, 1);
        tick();
        s_valid = 1'b0;
        chk("t1_issue", alu_issue, 1);
        chk("t1_op", alu_op, 0);
        chk("t1_inp1", alu_inp1, 5);
        chk("t1_inp2", alu_inp2, 7);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_issue_drop", alu_issue, 0);
        chk("t1_inp1_hold", alu_inp1, 5);
        chk("t1_mvalid_e1", m_valid, 0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("t1_mvalid_early", m_valid, 0);
        end
        tick();
        chk("t1_mvalid", m_valid, 1);
        chk("t1_mdata", m_data, 12);
        chk("t1_mlast", m_last, 1);
        chk("t1_busy_wait", busy, 1);
        tick();
        chk("t1_mvalid_after", m_valid, 0);
        chk("t1_busy_after", busy, 0);
        chk("t1_rx_count", rx_data.size(), 1);
        clear_rx();

        // Burst of 8 SUB under backpressure
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_cmd(2'd1, 100 + i, i, i == 7);
            chk("t2_ready", s_ready, 1);
            tick();
        end
        drive_cmd(2'd1, 200, 1, 1'b0);
        chk("t2_credits0", dut.credits, 0);
        chk("t2_blocked0", s_ready, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t2_blocked", s_ready, 0);
            chk("t2_no_issue", alu_issue, 0);
        end
        chk("t2_mvalid", m_valid, 1);
        chk("t2_mdata_head", m_data, 100);
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_rx(8, 40, "t2_count");
        for (int i = 0; i < 8; i++) begin
            chk("t2_data", rx_data[i], 100);
            chk("t2_last", rx_last[i], i == 7);
        end
        tick();
        chk("t2_busy_after", busy, 0);
        chk("t2_credits_after", dut.credits, 8);
        clear_rx();

        // Stream of 20 mixed ops with m_ready toggling
        sent = 0;
        cyc = 0;
        m_ready = 1'b0;
        while (sent < 20 && cyc < 300) begin
            exp3[sent] = (sent % 2 == 1) ? (1000 + sent * 7) - sent : (1000 + sent * 7) + sent;
            drive_cmd((sent % 2 == 1) ? 2'd1 : 2'd0, 1000 + sent * 7, sent, sent == 19);
            m_ready = ~m_ready;
            acc = s_ready;
            tick();
            cyc++;
            if (acc) begin
                sent++;
            end
        end
        s_valid = 1'b0;
        chk("t3_sent", sent, 20);
        while (rx_data.size() < 20 && cyc < 600) begin
            m_ready = ~m_ready;
            tick();
            cyc++;
        end
        chk("t3_count", rx_data.size(), 20);
        for (int i = 0; i < 20; i++) begin
            chk("t3_data", rx_data[i], exp3[i]);
            chk("t3_last", rx_last[i], i == 19);
        end
        m_ready = 1'b1;
        tick();
        chk("t3_busy_after", busy, 0);
        clear_rx();

        // Illegal opcode, then a legal packet
        drive_cmd(2'd3, 9, 4, 1'b1);
        chk("t4_ready", s_ready, 1);
        tick();
        s_valid = 1'b0;
        chk("t4_issue", alu_issue, 1);
        chk("t4_op_forced", alu_op, 0);
        chk("t4_err", err_op, 1);
        wait_rx(1, 20, "t4_count");
        chk("t4_data", rx_data[0], 0);
        chk("t4_last", rx_last[0], 1);
        tick();
        clear_rx();
        drive_cmd(2'd0, 1, 2, 1'b1);
        chk("t4b_ready", s_ready, 1);
        tick();
        s_valid = 1'b0;
        wait_rx(1, 20, "t4b_count");
        chk("t4b_data", rx_data[0], 3);
        chk("t4b_err_sticky", err_op, 1);
        tick();
        clear_rx();

        // Reset with 2 buffered and 3 in flight
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(2'd0, i + 1, 10, i == 4);
            chk("t5_ready", s_ready, 1);
            tick();
        end
        s_valid = 1'b0;
        tick();
        tick();
        chk("t5_buffered", m_valid, 1);
        chk("t5_head", m_data, 11);
        ap_rst_n = 1'b0;
        #1;
        chk("t5_s_ready", s_ready, 0);
        chk("t5_alu_issue", alu_issue, 0);
        chk("t5_alu_op", alu_op, 0);
        chk("t5_alu_inp1", alu_inp1, 0);
        chk("t5_alu_inp2", alu_inp2, 0);
        chk("t5_m_valid", m_valid, 0);
        chk("t5_m_data", m_data, 0);
        chk("t5_m_last", m_last, 0);
        chk("t5_busy", busy, 0);
        chk("t5_err_op", err_op, 0);
        @(posedge ap_clk);
        @(posedge ap_clk);
        #3 ap_rst_n = 1'b1;
        tick();
        chk("t5_rel_ready", s_ready, 1);
        chk("t5_rel_credits", dut.credits, 8);
        chk("t5_rel_mvalid", m_valid, 0);
        m_ready = 1'b1;
        repeat (8) tick();
        chk("t5_no_stale", rx_data.size(), 0);
        chk("t5_busy_after", busy, 0);
        clear_rx();

        // Command held during DRAIN waits for the m_last handshake
        m_ready = 1'b0;
        drive_cmd(2'd0, 10, 20, 1'b1);
        chk("t6_ready", s_ready, 1);
        tick();
        drive_cmd(2'd0, 30, 40, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t6_blocked", s_ready, 0);
            chk("t6_no_issue", alu_issue, 0);
        end
        chk("t6_mvalid", m_valid, 1);
        chk("t6_mdata", m_data, 30);
        m_ready = 1'b1;
        tick();
        chk("t6_ready_after", s_ready, 1);
        chk("t6_issue_not_yet", alu_issue, 0);
        chk("t6_popped", m_valid, 0);
        tick();
        s_valid = 1'b0;
        chk("t6_issue", alu_issue, 1);
        chk("t6_inp1", alu_inp1, 30);
        chk("t6_inp2", alu_inp2, 40);
        wait_rx(2, 20, "t6_count");
        chk("t6_first", rx_data[0], 30);
        chk("t6_second", rx_data[1], 70);
        chk("t6_second_last", rx_last[1], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
